// File: rtl/message_scheduler_pkg.sv
// Shared types and constants for the message scheduler.
// Holds FSM encodings, sigma rotate/shift amounts and sizing.
package message_scheduler_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 16;

    localparam logic [5:0] LAST_ROUND  = 6'd63;
    localparam logic [5:0] LAST_LOAD_T = 6'd14;

    localparam int unsigned S0_ROT_A = 7;
    localparam int unsigned S0_ROT_B = 18;
    localparam int unsigned S0_SHR   = 3;
    localparam int unsigned S1_ROT_A = 17;
    localparam int unsigned S1_ROT_B = 19;
    localparam int unsigned S1_SHR   = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_RISE,
        ADD1,
        ADD2,
        ADD3,
        WAIT_FALL,
        DONE
    } state_t;

    function automatic logic [WORD_W-1:0] rotr(
        input logic [WORD_W-1:0] x,
        input int unsigned       n
    );
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/adder_32bit.sv
// Plain 32-bit modular adder; the carry out is discarded.
module adder_32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/sigma_func_schedule.sv
// Small sigma functions used by the message expansion.
module sigma_func_schedule
    import message_scheduler_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] s0,
    output logic [WORD_W-1:0] s1
);

    assign s0 = rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
    assign s1 = rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);

endmodule

// File: rtl/message_scheduler.sv
// Expands a 512-bit block into 64 words, one per STN round.
// Words 16..63 are built in place with a single shared adder.
module message_scheduler
    import message_scheduler_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic         STN,
    output logic [31:0]  Wt_out,
    output logic         wt_valid,
    output logic         busy,
    output logic         done
);

    state_t            r_state;
    state_t            w_next_state;
    logic [WORD_W-1:0] r_buf [NUM_WORDS];
    logic [5:0]        r_t;
    logic [WORD_W-1:0] r_next;
    logic [WORD_W-1:0] r_acc;
    logic [WORD_W-1:0] r_wt;
    logic              r_wt_valid;
    logic              r_stn_d;
    logic              r_fall_pend;

    logic              w_rise;
    logic              w_fall;
    logic              w_commit;
    logic              w_need_add;
    logic [3:0]        w_slot_p1;
    logic [3:0]        w_slot_m1;
    logic [3:0]        w_slot_m6;
    logic [3:0]        w_slot_m14;
    logic [WORD_W-1:0] w_sig_x;
    logic [WORD_W-1:0] w_s0;
    logic [WORD_W-1:0] w_s1;
    logic [WORD_W-1:0] w_add_a;
    logic [WORD_W-1:0] w_add_b;
    logic [WORD_W-1:0] w_sum;

    assign w_rise = STN & ~r_stn_d;
    assign w_fall = ~STN & r_stn_d;

    // A fall seen during ADD1..ADD3 is held until the new word exists.
    assign w_commit = (r_state == WAIT_FALL) & (w_fall | r_fall_pend);

    assign w_need_add = (r_t > LAST_LOAD_T) && (r_t != LAST_ROUND);

    // Slot (t+1) mod 16 still holds W[t-15] until commit.
    assign w_slot_p1  = r_t[3:0] + 4'd1;
    assign w_slot_m1  = r_t[3:0] - 4'd1;
    assign w_slot_m6  = r_t[3:0] - 4'd6;
    assign w_slot_m14 = r_t[3:0] - 4'd14;

    assign w_sig_x = (r_state == ADD2) ? r_buf[w_slot_m14]
                                       : r_buf[w_slot_m1];

    sigma_func_schedule u_sigma (
        .x  (w_sig_x),
        .s0 (w_s0),
        .s1 (w_s1)
    );

    always_comb begin
        w_add_a = r_acc;
        w_add_b = r_buf[w_slot_p1];
        case (r_state)
            ADD1: begin
                w_add_a = w_s1;
                w_add_b = r_buf[w_slot_m6];
            end
            ADD2: w_add_b = w_s0;
            default: ;
        endcase
    end

    adder_32bit u_add (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .o_sum (w_sum)
    );

    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != IDLE);
        done         = (r_state == DONE);
        case (r_state)
            IDLE:      if (start) w_next_state = LOAD;
            LOAD:      w_next_state = WAIT_RISE;
            WAIT_RISE: begin
                if (w_rise) w_next_state = w_need_add ? ADD1 : WAIT_FALL;
            end
            ADD1:      w_next_state = ADD2;
            ADD2:      w_next_state = ADD3;
            ADD3:      w_next_state = WAIT_FALL;
            WAIT_FALL: begin
                if (w_commit) begin
                    w_next_state = (r_t == LAST_ROUND) ? DONE : WAIT_RISE;
                end
            end
            DONE:      w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_t         <= '0;
            r_next      <= '0;
            r_acc       <= '0;
            r_wt        <= '0;
            r_wt_valid  <= 1'b0;
            r_stn_d     <= 1'b0;
            r_fall_pend <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) r_buf[i] <= '0;
        end else begin
            r_state <= w_next_state;
            r_stn_d <= STN;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_WORDS; i++) begin
                            r_buf[i] <= block_in[511 - WORD_W*i -: WORD_W];
                        end
                    end
                end
                LOAD: begin
                    r_t         <= '0;
                    r_wt        <= r_buf[0];
                    r_wt_valid  <= 1'b1;
                    r_fall_pend <= 1'b0;
                end
                WAIT_RISE: begin
                    if (w_rise && r_t <= LAST_LOAD_T) begin
                        r_next <= r_buf[w_slot_p1];
                    end
                end
                ADD1, ADD2: begin
                    r_acc <= w_sum;
                    if (w_fall) r_fall_pend <= 1'b1;
                end
                ADD3: begin
                    r_next <= w_sum;
                    if (w_fall) r_fall_pend <= 1'b1;
                end
                WAIT_FALL: begin
                    if (w_commit) begin
                        r_fall_pend <= 1'b0;
                        if (r_t == LAST_ROUND) begin
                            r_wt_valid <= 1'b0;
                        end else begin
                            r_t              <= r_t + 6'd1;
                            r_wt             <= r_next;
                            r_buf[w_slot_p1] <= r_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign Wt_out   = r_wt;
    assign wt_valid = r_wt_valid;

endmodule

// File: tb/tb_message_scheduler.sv
// Self-checking bench for message_scheduler: directed table,
// corner sequences (short strobe, stray start, abort) and random blocks.
module tb_message_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [511:0] block_in;
    logic         STN;
    logic [31:0]  Wt_out;
    logic         wt_valid;
    logic         busy;
    logic         done;

    message_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .block_in (block_in),
        .STN      (STN),
        .Wt_out   (Wt_out),
        .wt_valid (wt_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rnd;
        logic [31:0] exp;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] ref_w [64];
    logic [31:0] got_w [64];
    bit          stable_bad;
    bit          valid_bad;
    bit          hold_bad;
    bit          rst_bad;
    int          done_cnt;
    int          done_r;
    int          done_i;
    vec_t        tbl [8];
    logic [511:0] abc_blk;
    logic [511:0] rnd_blk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] m_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] m_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    task automatic gen_ref(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) ref_w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            ref_w[i] = m_s1(ref_w[i-2]) + ref_w[i-7]
                     + m_s0(ref_w[i-15]) + ref_w[i-16];
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
        return b;
    endfunction

    // 64 rounds, STN 4 high / 4 low (1 high in short_rnd).
    task automatic run_block(input logic [511:0] blk, input int short_rnd,
                             input int start_rnd, input int abort_rnd);
        int hi;
        stable_bad = 0;
        valid_bad  = 0;
        hold_bad   = 0;
        rst_bad    = 0;
        done_cnt   = 0;
        done_r     = -1;
        done_i     = -1;
        @(posedge clk); #1;
        start    = 1'b1;
        block_in = blk;
        @(posedge clk); #1;
        start    = 1'b0;
        block_in = ~blk;
        @(posedge clk); #1;
        for (int r = 0; r < 64; r++) begin
            if (r == abort_rnd) begin
                rst_n = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (done === 1'b1) done_cnt++;
                    if (k > 0 && (Wt_out !== 32'h0 || wt_valid !== 1'b0 ||
                                  busy !== 1'b0 || done !== 1'b0))
                        rst_bad = 1;
                    @(posedge clk); #1;
                end
                rst_n = 1'b1;
                return;
            end
            STN = 1'b1;
            hi  = (r == short_rnd) ? 1 : 4;
            for (int c = 0; c < hi; c++) begin
                if (r == start_rnd && c == 0) begin
                    start    = 1'b1;
                    block_in = {16{32'hDEADBEEF}};
                end
                @(negedge clk);
                if (c == 0) got_w[r] = Wt_out;
                else if (Wt_out !== got_w[r]) stable_bad = 1;
                if (wt_valid !== 1'b1) valid_bad = 1;
                if (done === 1'b1) done_cnt++;
                @(posedge clk); #1;
                start    = 1'b0;
                block_in = ~blk;
            end
            STN = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    done_cnt++;
                    done_r = r;
                    done_i = c;
                end
                if (!(r == 63 && c > 0) && wt_valid !== 1'b1) valid_bad = 1;
                if (r == short_rnd && Wt_out !== got_w[r]) hold_bad = 1;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_block(input string tag);
        for (int r = 0; r < 64; r++) begin
            check($sformatf("%s W%0d", tag, r), got_w[r], ref_w[r]);
        end
        check({tag, " stable"}, 32'(stable_bad), 32'd0);
        check({tag, " valid_held"}, 32'(valid_bad), 32'd0);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " done_round"}, done_r, 63);
        check({tag, " done_cycle"}, done_i, 1);
        @(negedge clk);
        check({tag, " valid_end"}, 32'(wt_valid), 32'd0);
        check({tag, " busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        STN      = 1'b0;
        block_in = '0;
        abc_blk  = {32'h61626380, 448'h0, 32'h00000018};

        tbl[0] = '{0,  32'h61626380};
        tbl[1] = '{1,  32'h00000000};
        tbl[2] = '{14, 32'h00000000};
        tbl[3] = '{15, 32'h00000018};
        tbl[4] = '{16, 32'h61626380};
        tbl[5] = '{17, 32'h000F0000};
        tbl[6] = '{18, 32'h7DA86405};
        tbl[7] = '{19, 32'h600003C6};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset Wt_out", Wt_out, 32'h0);
        check("reset wt_valid", 32'(wt_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        gen_ref(abc_blk);
        run_block(abc_blk, -1, -1, -1);
        foreach (tbl[i]) begin
            check($sformatf("abc table W%0d", tbl[i].rnd),
                  got_w[tbl[i].rnd], tbl[i].exp);
        end
        check_block("abc");

        run_block(abc_blk, 20, -1, -1);
        check("short W21", got_w[21], ref_w[21]);
        check("short hold", 32'(hold_bad), 32'd0);
        check_block("short");

        run_block(abc_blk, -1, 30, -1);
        check_block("stray_start");

        rnd_blk = rand_block();
        run_block(rnd_blk, -1, -1, 40);
        check("abort outputs", 32'(rst_bad), 32'd0);
        check("abort done", done_cnt, 0);
        run_block(abc_blk, -1, -1, -1);
        check("after_abort W0", got_w[0], 32'h61626380);
        check_block("after_abort");

        for (int b = 0; b < 20; b++) begin
            rnd_blk = rand_block();
            gen_ref(rnd_blk);
            run_block(rnd_blk, -1, -1, -1);
            check_block($sformatf("rand%0d", b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
